pipe_stage_reg: RTL and testbench

Parametrised pipeline boundary register and successor to the fixed-field EX/MEM register. It carries an opaque payload with a valid bit between stage STAGE and stage STAGE+1, driven by the global stall vector and the flush line. It also carries a side channel for multi-cycle-operation state (the madd/msub counter and partial product) that passes back while the upstream stage is stopped. A saturating per-boundary stall-cycle counter supports performance debug.

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/pipe_stage_reg_sat_counter.sv | 25 ++
 rtl/pipe_stage_reg.sv | 98 +++++++++
 tb/tb_pipe_stage_reg.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: stall encoding, write-enable encoding,
// zero word, and the EX/MEM payload field order.
package cpu_pkg;

  localparam int STALL_W = 6;

  localparam logic Stop    = 1'b1;
  localparam logic NotStop = 1'b0;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Field order packed into the 32-bit boundary payload, MSB first.
  typedef struct packed {
    logic [7:0]  aluop;
    logic [4:0]  wd;
    logic        wreg;
    logic        whilo;
    logic        mem_we;
    logic [15:0] imm_lo;
  } ex_mem_payload_t;

  localparam int EX_MEM_W = $bits(ex_mem_payload_t);

  function automatic logic [EX_MEM_W-1:0] pack_ex_mem(
    input ex_mem_payload_t p
  );
    return p;
  endfunction

  function automatic ex_mem_payload_t unpack_ex_mem(
    input logic [EX_MEM_W-1:0] w
  );
    return ex_mem_payload_t'(w);
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (async, active-low), clr, inc, count.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MAX = '1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != MAX) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register between stage STAGE and STAGE+1.
// Ports: clk, rst (async, active-low), stall vector, flush,
// perf_clr; in_valid/in_payload/in_carry from upstream;
// out_valid/out_payload downstream, out_carry back upstream,
// bubble_o one-cycle bubble flag, stall_cnt saturating hold count.
module pipe_stage_reg #(
  parameter int               WIDTH       = 32,
  parameter int               CARRY_W     = 66,
  parameter int               STALL_W     = 6,
  parameter int               STAGE       = 3,
  parameter logic [WIDTH-1:0] NOP_PAYLOAD = '0,
  parameter int               CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               perf_clr,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_payload,
  input  logic [CARRY_W-1:0] in_carry,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_payload,
  output logic [CARRY_W-1:0] out_carry,
  output logic               bubble_o,
  output logic [CNT_W-1:0]   stall_cnt
);

  import cpu_pkg::*;

  logic up;
  logic dn;
  logic do_flush;
  logic do_bubble;
  logic do_adv;
  logic cnt_inc;

  assign up = stall[STAGE];
  assign dn = stall[STAGE+1];

  // Mutually exclusive actions; flush dominates every stall mix.
  // up=0 with dn=1 cannot come from the controller and is
  // folded into advance.
  assign do_flush  = flush;
  assign do_bubble = !flush && up == Stop && dn == NotStop;
  assign do_adv    = !flush && up == NotStop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_payload <= NOP_PAYLOAD;
      out_carry   <= '0;
      bubble_o    <= 1'b0;
    end else begin
      unique case (1'b1)
        do_flush: begin
          out_valid   <= 1'b0;
          out_payload <= NOP_PAYLOAD;
          out_carry   <= '0;
          bubble_o    <= 1'b0;
        end
        do_bubble: begin
          out_valid   <= 1'b0;
          out_payload <= NOP_PAYLOAD;
          out_carry   <= in_carry;
          bubble_o    <= 1'b1;
        end
        do_adv: begin
          out_valid   <= in_valid;
          out_payload <= in_payload;
          out_carry   <= '0;
          bubble_o    <= 1'b0;
        end
        default: begin
          // Hold: the instruction stays put while the stopped
          // upstream stage sees its own multi-cycle state.
          out_carry <= in_carry;
          bubble_o  <= 1'b0;
        end
      endcase
    end
  end

  // A held cycle is one where downstream is stopped on a real
  // instruction and the boundary is not being killed.
  assign cnt_inc = dn && out_valid && !flush;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (perf_clr),
    .inc  (cnt_inc),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized bench for pipe_stage_reg with an in-bench model,
// a per-cycle compare process and directed literal checks.
module tb_pipe_stage_reg;

  import cpu_pkg::*;

  localparam int SG = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic        perf_clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_payload = '0;
  logic [65:0] in_carry = '0;

  logic        o_valid, v4;
  logic [31:0] o_payload, p4;
  logic [65:0] o_carry, c4;
  logic        o_bubble, b4;
  logic [15:0] o_cnt;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;
  bit en = 1'b0;

  logic        m_valid;
  logic [31:0] m_payload;
  logic [65:0] m_carry;
  logic        m_bubble;
  int          m_cnt16;
  int          m_cnt4;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .perf_clr(perf_clr), .in_valid(in_valid),
    .in_payload(in_payload), .in_carry(in_carry),
    .out_valid(o_valid), .out_payload(o_payload),
    .out_carry(o_carry), .bubble_o(o_bubble),
    .stall_cnt(o_cnt)
  );

  pipe_stage_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .perf_clr(perf_clr), .in_valid(in_valid),
    .in_payload(in_payload), .in_carry(in_carry),
    .out_valid(v4), .out_payload(p4),
    .out_carry(c4), .bubble_o(b4),
    .stall_cnt(cnt4)
  );

  task automatic check(input string nm,
                       input logic [65:0] act,
                       input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid   = 1'b0;
    m_payload = '0;
    m_carry   = '0;
    m_bubble  = 1'b0;
    m_cnt16   = 0;
    m_cnt4    = 0;
  endtask

  // Boundary rules applied once per rising edge.
  task automatic model_edge();
    bit up, dn, inc;
    up  = stall[SG];
    dn  = stall[SG+1];
    inc = dn && m_valid && !flush;
    if (perf_clr) begin
      m_cnt16 = 0;
      m_cnt4  = 0;
    end else begin
      m_cnt16 = (m_cnt16 + int'(inc) > 65535) ? 65535 : m_cnt16 + int'(inc);
      m_cnt4  = (m_cnt4 + int'(inc) > 15) ? 15 : m_cnt4 + int'(inc);
    end
    if (flush) begin
      m_valid = 0; m_payload = 0; m_carry = 0; m_bubble = 0;
    end else if (up && !dn) begin
      m_valid = 0; m_payload = 0; m_carry = in_carry; m_bubble = 1;
    end else if (!up) begin
      m_valid = in_valid; m_payload = in_payload;
      m_carry = 0; m_bubble = 0;
    end else begin
      m_carry = in_carry; m_bubble = 0;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic [5:0] s, input logic f,
                      input logic pc, input logic v,
                      input logic [31:0] p, input logic [65:0] c);
    stall = s; flush = f; perf_clr = pc;
    in_valid = v; in_payload = p; in_carry = c;
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    model_reset();
    #1;
  endtask

  always @(posedge clk)
    if (rst)
      assert (!(stall[SG+1] && !stall[SG]))
        else $error("illegal stall pattern");

  always @(negedge clk) begin
    if (en) begin
      check("valid", 66'(o_valid), 66'(m_valid));
      check("payload", 66'(o_payload), 66'(m_payload));
      check("carry", o_carry, m_carry);
      check("bubble", 66'(o_bubble), 66'(m_bubble));
      check("cnt16", 66'(o_cnt), 66'(m_cnt16));
      check("valid4", 66'(v4), 66'(m_valid));
      check("payload4", 66'(p4), 66'(m_payload));
      check("carry4", c4, m_carry);
      check("cnt4", 66'(cnt4), 66'(m_cnt4));
    end
  end

  localparam logic [65:0] CB = {2'b01, 64'h0000_0001_0000_0002};

  initial begin
    logic [65:0] c;
    logic [5:0]  s;
    ex_mem_payload_t pl;
    int r;
    model_reset();
    #1 rst = 1'b0;
    en = 1'b1;
    @(negedge clk);
    check("rst_valid", 66'(o_valid), 66'(0));
    check("rst_payload", 66'(o_payload), 66'(0));
    check("rst_carry", o_carry, 66'(0));
    check("rst_bubble", 66'(o_bubble), 66'(0));
    check("rst_cnt", 66'(o_cnt), 66'(0));
    rst = 1'b1;

    // reset in the middle of a hold
    step(6'b000000, 0, 0, 1, 32'hDEADBEEF, '0);
    step(6'b011000, 0, 0, 1, 32'h0, CB);
    check("hold_dead", 66'(o_payload), 66'(32'hDEADBEEF));
    async_reset();
    check("mid_rst_valid", 66'(o_valid), 66'(0));
    check("mid_rst_payload", 66'(o_payload), 66'(0));
    check("mid_rst_carry", o_carry, 66'(0));
    @(negedge clk);
    rst = 1'b1;
    step(6'b011000, 0, 0, 1, 32'h1111_2222, CB);
    check("post_rst_valid", 66'(o_valid), 66'(0));
    check("post_rst_payload", 66'(o_payload), 66'(0));

    // advance
    step(6'b000000, 0, 0, 1, 32'h12345678, CB);
    check("adv_valid", 66'(o_valid), 66'(1));
    check("adv_payload", 66'(o_payload), 66'(32'h12345678));
    check("adv_carry", o_carry, 66'(0));
    check("adv_bubble", 66'(o_bubble), 66'(0));

    // bubble with carry
    step(6'b001000, 0, 0, 1, 32'h0000_0055, CB);
    check("bub_valid", 66'(o_valid), 66'(0));
    check("bub_payload", 66'(o_payload), 66'(0));
    check("bub_carry", o_carry, CB);
    check("bub_pulse", 66'(o_bubble), 66'(1));
    step(6'b000000, 0, 0, 0, 32'h0, '0);
    check("bub_drop", 66'(o_bubble), 66'(0));

    // hold for three cycles
    step(6'b000000, 0, 1, 1, 32'hA5A5A5A5, '0);
    repeat (3) step(6'b011000, 0, 0, 1, 32'h0, CB);
    check("hold_payload", 66'(o_payload), 66'(32'hA5A5A5A5));
    check("hold_valid", 66'(o_valid), 66'(1));
    check("hold_cnt", 66'(o_cnt), 66'(3));

    // flush over stall
    step(6'b011000, 1, 0, 1, 32'h0, CB);
    check("fl_valid", 66'(o_valid), 66'(0));
    check("fl_payload", 66'(o_payload), 66'(0));
    check("fl_carry", o_carry, 66'(0));
    check("fl_cnt", 66'(o_cnt), 66'(3));

    // saturation of the narrow counter
    step(6'b000000, 0, 0, 1, 32'hCAFE0001, '0);
    repeat (20) step(6'b011000, 0, 0, 1, 32'h0, CB);
    check("sat_cnt4", 66'(cnt4), 66'(15));
    check("sat_cnt16", 66'(o_cnt), 66'(23));
    step(6'b011000, 0, 1, 1, 32'h0, CB);
    check("clr_cnt4", 66'(cnt4), 66'(0));
    check("clr_cnt16", 66'(o_cnt), 66'(0));

    // randomized traffic, legal stall patterns only
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
        @(negedge clk);
        rst = 1'b1;
      end
      r = $urandom_range(0, 9);
      s = 6'($urandom);
      if (r < 4) begin
        s[SG] = 1'b0; s[SG+1] = 1'b0;
      end else if (r < 6) begin
        s[SG] = 1'b1; s[SG+1] = 1'b0;
      end else begin
        s[SG] = 1'b1; s[SG+1] = 1'b1;
      end
      pl.aluop  = 8'($urandom);
      pl.wd     = 5'($urandom);
      pl.wreg   = $urandom_range(0, 1) ? WriteEnable : WriteDisable;
      pl.whilo  = 1'($urandom);
      pl.mem_we = 1'($urandom);
      pl.imm_lo = 16'($urandom);
      c = {2'($urandom), $urandom, $urandom};
      step(s, $urandom_range(0, 15) == 0,
           $urandom_range(0, 31) == 0,
           $urandom_range(0, 3) != 0,
           pack_ex_mem(pl), c);
    end

    en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
